bist16_ctrl: RTL and testbench

//  Built-in self-test controller for 16-bit bitwise datapath units (and16, or16, ...).

---
 rtl/bist16_ctrl.sv | 124 ++++++++++++
 tb/tb_bist16_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bist16_ctrl.sv
// BIST controller for 16-bit bitwise datapath units: issues LFSR operand pairs,
// compacts the DUT response into a MISR signature and flags pass against a golden value.
module bist16_ctrl #(
  parameter int          NUM_VECTORS = 64,
  parameter int          DUT_LAT     = 0,
  parameter logic [15:0] SEED_A      = 16'hACE1,
  parameter logic [15:0] SEED_B      = 16'h1D0F,
  parameter logic [15:0] GOLDEN_SIG  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] dut_y,
  output logic [15:0] pat_a,
  output logic [15:0] pat_b,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [15:0] LAST_VEC   = 16'(NUM_VECTORS - 1);
  localparam logic [1:0]  LAST_FLUSH = 2'(DUT_LAT - 1);

  logic [1:0]  state;
  logic [15:0] count;
  logic [1:0]  flush_cnt;
  logic        reload;
  logic        run_last;
  logic        flush_last;
  logic        capture;
  logic [15:0] sig_d;

  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  endfunction

  function automatic logic [15:0] misr_next(input logic [15:0] sig, input logic [15:0] y);
    return {sig[14:0], sig[15] ^ sig[13] ^ sig[12] ^ sig[10]} ^ y;
  endfunction

  assign reload     = start && ((state == IDLE) || (state == DONE));
  assign run_last   = (state == RUN) && (count == LAST_VEC);
  assign flush_last = (state == FLUSH) && (flush_cnt == LAST_FLUSH);
  assign sig_d      = capture ? misr_next(signature, dut_y) : signature;
  assign busy       = (state == RUN) || (state == FLUSH);
  assign done       = (state == DONE);

  // Valid pipe: tracks which result slots carry a real vector DUT_LAT cycles after issue
  generate
    if (DUT_LAT == 0) begin : g_lat0
      assign capture = (state == RUN);
    end else begin : g_latn
      logic [DUT_LAT-1:0] vld_p;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_p <= '0;
        end else if (reload) begin
          vld_p <= '0;
        end else begin
          vld_p[0] <= (state == RUN);
          for (int i = 1; i < DUT_LAT; i++) begin
            vld_p[i] <= vld_p[i-1];
          end
        end
      end

      assign capture = vld_p[DUT_LAT-1];
    end
  endgenerate

  // Control, pattern generators and signature register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pat_a     <= SEED_A;
      pat_b     <= SEED_B;
      signature <= '0;
      count     <= '0;
      flush_cnt <= '0;
      pass      <= 1'b0;
    end else if (reload) begin
      state     <= RUN;
      pat_a     <= SEED_A;
      pat_b     <= SEED_B;
      signature <= '0;
      count     <= '0;
      flush_cnt <= '0;
      pass      <= 1'b0;
    end else begin
      signature <= sig_d;
      case (state)
        RUN: begin
          pat_a <= lfsr_next(pat_a);
          pat_b <= lfsr_next(pat_b);
          count <= count + 16'd1;
          if (run_last) begin
            if (DUT_LAT == 0) begin
              state <= DONE;
              pass  <= (sig_d == GOLDEN_SIG);
            end else begin
              state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          flush_cnt <= flush_cnt + 2'd1;
          if (flush_last) begin
            state <= DONE;
            pass  <= (sig_d == GOLDEN_SIG);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bist16_ctrl.sv
// Bench for bist16_ctrl: three instances with different vector counts and latencies,
// checked against a sequence-level reference of the operand streams and signature fold.
module tb_bist16_ctrl;

  localparam int N2 = 40;

  function automatic logic [15:0] lfsr_ref(input logic [15:0] q);
    return (q << 1) | {15'd0, ^(q & 16'hB400)};
  endfunction

  function automatic logic [15:0] misr_ref(input logic [15:0] s, input logic [15:0] y);
    return ((s << 1) | {15'd0, ^(s & 16'hB400)}) ^ y;
  endfunction

  function automatic logic [15:0] unit_op(input int op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      0:       return a & b;
      1:       return a | b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic [15:0] ref_sig(input int n, input int op, input logic [15:0] mask);
    logic [15:0] a, b, s;
    a = 16'hACE1;
    b = 16'h1D0F;
    s = 16'h0000;
    for (int i = 0; i < n; i++) begin
      s = misr_ref(s, unit_op(op, a, b) | mask);
      a = lfsr_ref(a);
      b = lfsr_ref(b);
    end
    return s;
  endfunction

  localparam logic [15:0] G2 = ref_sig(N2, 0, 16'h0000);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic [15:0] y0 = 16'h0001;
  logic [15:0] y2;
  logic [15:0] pa0, pb0, sig0, pa1, pb1, sig1, pa2, pb2, sig2;
  logic busy0, done0, pass0, busy1, done1, pass1, busy2, done2, pass2;
  int op2 = 0;
  logic [15:0] mask2 = 16'h0000;
  logic [15:0] hist2 [0:2];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // behavioural unit under test for u2: 3-cycle latency bitwise op with optional stuck bits
  always @(posedge clk) begin
    hist2[0] <= unit_op(op2, pa2, pb2) | mask2;
    hist2[1] <= hist2[0];
    hist2[2] <= hist2[1];
  end
  assign y2 = hist2[2];

  bist16_ctrl #(.NUM_VECTORS(2), .DUT_LAT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .dut_y(y0), .pat_a(pa0), .pat_b(pb0),
    .busy(busy0), .done(done0), .pass(pass0), .signature(sig0));

  bist16_ctrl #(.NUM_VECTORS(64), .DUT_LAT(2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .dut_y(16'h0000), .pat_a(pa1), .pat_b(pb1),
    .busy(busy1), .done(done1), .pass(pass1), .signature(sig1));

  bist16_ctrl #(.NUM_VECTORS(N2), .DUT_LAT(3), .GOLDEN_SIG(G2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .dut_y(y2), .pat_a(pa2), .pat_b(pb2),
    .busy(busy2), .done(done2), .pass(pass2), .signature(sig2));

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (pa0 !== 16'hACE1) begin bad++; $display("FAIL reset_pat_a got=%h exp=%h", pa0, 16'hACE1); end
    total++; if (pb0 !== 16'h1D0F) begin bad++; $display("FAIL reset_pat_b got=%h exp=%h", pb0, 16'h1D0F); end
    total++; if (sig0 !== 16'h0000) begin bad++; $display("FAIL reset_sig got=%h exp=0000", sig0); end
    total++; if ({busy0, done0, pass0} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {busy0, done0, pass0}); end
    total++; if ({busy1, done1, pass1, busy2, done2, pass2} !== 6'd0) begin bad++; $display("FAIL reset_flags_u1u2 got=%b exp=000000", {busy1, done1, pass1, busy2, done2, pass2}); end
  endtask

  task automatic test_lfsr_step();
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    total++; if (busy0 !== 1'b1 || pa0 !== 16'hACE1) begin bad++; $display("FAIL run_entry busy=%b pat_a=%h exp busy=1 pat_a=ace1", busy0, pa0); end
    @(posedge clk); #1;
    total++; if (pa0 !== 16'h59C3) begin bad++; $display("FAIL step_pat_a got=%h exp=59c3", pa0); end
    total++; if (pb0 !== 16'h3A1E) begin bad++; $display("FAIL step_pat_b got=%h exp=3a1e", pb0); end
    @(posedge clk); #1;
  endtask

  task automatic test_small_run();
    int cyc, guard;
    y0 = 16'h0001;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    cyc = 0; guard = 0;
    while (!done0 && guard < 20) begin
      if (busy0) cyc++;
      @(posedge clk); #1;
      guard++;
    end
    total++; if (done0 !== 1'b1) begin bad++; $display("FAIL small_done got=%b exp=1", done0); end
    total++; if (cyc != 2) begin bad++; $display("FAIL small_run_cycles got=%0d exp=2", cyc); end
    total++; if (sig0 !== 16'h0003) begin bad++; $display("FAIL small_sig got=%h exp=0003", sig0); end
    total++; if (pass0 !== 1'b0 || busy0 !== 1'b0) begin bad++; $display("FAIL small_pass_busy got=%b%b exp=00", pass0, busy0); end
  endtask

  task automatic test_flush_latency();
    int cyc, guard;
    bit early_pass;
    early_pass = 0;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    cyc = 0; guard = 0;
    while (!done1 && guard < 300) begin
      if (busy1) cyc++;
      if (pass1) early_pass = 1;
      @(posedge clk); #1;
      guard++;
    end
    total++; if (done1 !== 1'b1) begin bad++; $display("FAIL flush_done got=%b exp=1", done1); end
    total++; if (cyc != 66) begin bad++; $display("FAIL flush_busy_cycles got=%0d exp=66", cyc); end
    total++; if (sig1 !== 16'h0000) begin bad++; $display("FAIL flush_sig got=%h exp=0000", sig1); end
    total++; if (pass1 !== 1'b1) begin bad++; $display("FAIL flush_pass got=%b exp=1", pass1); end
    total++; if (early_pass) begin bad++; $display("FAIL pass_before_done got=1 exp=0"); end
  endtask

  task automatic test_model();
    int cyc, guard, gap, poke;
    logic [15:0] exp;
    for (int r = 0; r < 6; r++) begin
      if (r == 0) begin
        op2 = 0; mask2 = 16'h0000;
      end else if (r == 5) begin
        op2 = 0; mask2 = 16'h0001 << $urandom_range(15, 0);
      end else begin
        op2 = $urandom_range(2, 0); mask2 = 16'h0000;
      end
      exp = ref_sig(N2, op2, mask2);
      gap = $urandom_range(3, 0);
      repeat (gap) begin @(posedge clk); #1; end
      start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      poke = $urandom_range(N2 - 2, 1);
      cyc = 0; guard = 0;
      while (!done2 && guard < 500) begin
        if (busy2) cyc++;
        start2 = (cyc == poke);
        @(posedge clk); #1;
        guard++;
      end
      start2 = 1'b0;
      total++; if (done2 !== 1'b1) begin bad++; $display("FAIL model_done run=%0d got=%b exp=1", r, done2); end
      total++; if (cyc != N2 + 3) begin bad++; $display("FAIL model_busy_cycles run=%0d got=%0d exp=%0d", r, cyc, N2 + 3); end
      total++; if (sig2 !== exp) begin bad++; $display("FAIL model_sig run=%0d op=%0d mask=%h got=%h exp=%h", r, op2, mask2, sig2, exp); end
      total++; if (pass2 !== (exp == G2)) begin bad++; $display("FAIL model_pass run=%0d got=%b exp=%b", r, pass2, (exp == G2)); end
      if (r == 0) begin
        total++; if (pass2 !== 1'b1) begin bad++; $display("FAIL fault_free_pass got=%b exp=1", pass2); end
      end
      if (r == 5) begin
        total++; if (pass2 !== 1'b0) begin bad++; $display("FAIL stuck_bit_pass mask=%h got=%b exp=0", mask2, pass2); end
      end
    end
    mask2 = 16'h0000;
  endtask

  task automatic test_rerun_from_done();
    int guard;
    logic [15:0] s [0:1];
    logic [15:0] exp;
    y0 = 16'h1234;
    exp = misr_ref(misr_ref(16'h0000, y0), y0);
    for (int k = 0; k < 2; k++) begin
      start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      total++; if (done0 !== 1'b0 || busy0 !== 1'b1) begin bad++; $display("FAIL rerun_entry run=%0d done=%b busy=%b exp 0 1", k, done0, busy0); end
      guard = 0;
      while (!done0 && guard < 20) begin @(posedge clk); #1; guard++; end
      s[k] = sig0;
    end
    total++; if (s[1] !== s[0]) begin bad++; $display("FAIL rerun_identical got=%h exp=%h", s[1], s[0]); end
    total++; if (s[0] !== exp) begin bad++; $display("FAIL rerun_sig got=%h exp=%h", s[0], exp); end
  endtask

  task automatic test_reset_midrun();
    op2 = $urandom_range(2, 0);
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #3 rst_n = 1'b0;
    #1;
    total++; if (pa2 !== 16'hACE1 || pb2 !== 16'h1D0F) begin bad++; $display("FAIL midrun_rst_pats got=%h %h exp=ace1 1d0f", pa2, pb2); end
    total++; if (sig2 !== 16'h0000) begin bad++; $display("FAIL midrun_rst_sig got=%h exp=0000", sig2); end
    total++; if ({busy2, done2, pass2} !== 3'b000) begin bad++; $display("FAIL midrun_rst_flags got=%b exp=000", {busy2, done2, pass2}); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (N2 + 6) begin
      @(posedge clk); #1;
      total++; if (done2 !== 1'b0 || busy2 !== 1'b0) begin bad++; $display("FAIL after_rst_idle done=%b busy=%b exp 0 0", done2, busy2); end
    end
  endtask

  initial begin
    test_reset();
    test_lfsr_step();
    test_small_run();
    test_flush_latency();
    test_model();
    test_rerun_from_done();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
